// File: rtl/coarse_counter_mc.sv
// -----------------------------------------------------------------------------
// coarse_counter_mc
//
// Multi-channel coarse counter for the TDC path. A common start clears a
// shared WIDTH-bit cycle counter. Each of NCH stop channels latches the count
// at its first stop. Completion is reported with Valid_CC and released by
// ack_CC. Overflow_CC flags that the counter saturated before every channel
// stopped.
//
// Parameters
//   WIDTH        coarse counter / per-channel result width (>= 4)
//   NCH          number of stop channels (1..16)
//
// Ports
//   clk_CC       in   counter clock, rising edge
//   reset_CC     in   synchronous active-high reset
//   start_CC     in   common start, sampled in IDLE only
//   stop_CC      in   per-channel stop, bit i = channel i
//   ack_CC       in   readout acknowledge, sampled in DONE only
//   Valid_CC     out  results complete and stable
//   Overflow_CC  out  counter saturated before all channels stopped
//   Hit_CC       out  bit i set = channel i captured a stop
//   CountOutCC   out  channel i count in bits [i*WIDTH +: WIDTH]
//
// Build option
//   CC_STOP_EDGE_EN  defined: a channel fires on a 0->1 transition of its
//                    stop input. Undefined: a channel fires on a high level.
// -----------------------------------------------------------------------------
module coarse_counter_mc #(
    parameter int WIDTH = 12,
    parameter int NCH   = 4
) (
    input  logic                 clk_CC,
    input  logic                 reset_CC,
    input  logic                 start_CC,
    input  logic [NCH-1:0]       stop_CC,
    input  logic                 ack_CC,
    output logic                 Valid_CC,
    output logic                 Overflow_CC,
    output logic [NCH-1:0]       Hit_CC,
    output logic [NCH*WIDTH-1:0] CountOutCC
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] C_ALL_ONES = {WIDTH{1'b1}};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_cnt;
    logic [NCH-1:0]         r_hit;
    logic [NCH*WIDTH-1:0]   r_count;
    logic                   r_ovf;
    logic                   r_valid;

    logic [WIDTH-1:0]       w_cnt_inc;
    logic                   w_sat;
    logic [NCH-1:0]         w_stop_act;
    logic [NCH-1:0]         w_fire;
    logic [NCH-1:0]         w_hit_nxt;
    logic                   w_all_hit;

`ifdef CC_STOP_EDGE_EN
    // Previous-cycle copy of the stop inputs, kept in every state so a stop
    // already high when the run starts is not mistaken for a fresh edge.
    logic [NCH-1:0] r_stop_prev;

    always_ff @(posedge clk_CC) begin
        if (reset_CC) begin
            r_stop_prev <= '0;
        end else begin
            r_stop_prev <= stop_CC;
        end
    end

    assign w_stop_act = stop_CC & ~r_stop_prev;
`else
    assign w_stop_act = stop_CC;
`endif

    // The value captured at an edge is the count after that edge, so a stop
    // at the n-th edge after start reads n.
    assign w_cnt_inc = r_cnt + C_ONE;
    // All-ones is reserved for overflow, so the run ends one step before wrap.
    assign w_sat     = (w_cnt_inc == C_ALL_ONES);
    // First stop wins: only channels not yet hit may fire.
    assign w_fire    = w_stop_act & ~r_hit;
    assign w_hit_nxt = r_hit | w_fire;
    assign w_all_hit = &w_hit_nxt;

    always_ff @(posedge clk_CC) begin
        if (reset_CC) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_CC) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_all_hit || w_sat) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (ack_CC) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_CC) begin
        if (reset_CC) begin
            r_cnt   <= '0;
            r_hit   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            // Valid follows the state being entered, so it rises right after
            // the final capture edge and drops right after the ack edge.
            r_valid <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start_CC) begin
                        r_cnt   <= '0;
                        r_hit   <= '0;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_cnt <= w_cnt_inc;
                    r_hit <= w_hit_nxt;
                    // On saturation w_cnt_inc is all-ones, so unhit channels
                    // and channels firing at that edge both load all-ones.
                    for (int i = 0; i < NCH; i++) begin
                        if (w_fire[i] || (w_sat && !w_hit_nxt[i])) begin
                            r_count[i*WIDTH +: WIDTH] <= w_cnt_inc;
                        end
                    end
                    // A complete set of hits on the saturating edge is a
                    // valid (non-overflowed) result.
                    r_ovf <= w_sat && !w_all_hit;
                end
                default: begin
                end
            endcase
        end
    end

    assign Valid_CC    = r_valid;
    assign Overflow_CC = r_ovf;
    assign Hit_CC      = r_hit;
    assign CountOutCC  = r_count;

endmodule

// File: tb/tb_coarse_counter_mc.sv
module tb_coarse_counter_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // DUT A: WIDTH=12, NCH=4
    logic        st_a, ak_a;
    logic [3:0]  sp_a;
    logic        vld_a, ovf_a;
    logic [3:0]  hit_a;
    logic [47:0] cnt_a;

    // DUT B: WIDTH=4, NCH=4
    logic        st_b, ak_b;
    logic [3:0]  sp_b;
    logic        vld_b, ovf_b;
    logic [3:0]  hit_b;
    logic [15:0] cnt_b;

    int checks = 0;
    int errors = 0;

    coarse_counter_mc #(.WIDTH(12), .NCH(4)) u_dut_a (
        .clk_CC(clk), .reset_CC(rst), .start_CC(st_a), .stop_CC(sp_a),
        .ack_CC(ak_a), .Valid_CC(vld_a), .Overflow_CC(ovf_a),
        .Hit_CC(hit_a), .CountOutCC(cnt_a)
    );

    coarse_counter_mc #(.WIDTH(4), .NCH(4)) u_dut_b (
        .clk_CC(clk), .reset_CC(rst), .start_CC(st_b), .stop_CC(sp_b),
        .ack_CC(ak_b), .Valid_CC(vld_b), .Overflow_CC(ovf_b),
        .Hit_CC(hit_b), .CountOutCC(cnt_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (vld_a !== 1'b0 || ovf_a !== 1'b0) begin errors++; $display("FAIL reset_a_flags: vld=%b ovf=%b want 0 0", vld_a, ovf_a); end
        checks++; if (hit_a !== 4'h0 || cnt_a !== 48'h0) begin errors++; $display("FAIL reset_a_data: hit=%h cnt=%h want 0 0", hit_a, cnt_a); end
        checks++; if (vld_b !== 1'b0 || ovf_b !== 1'b0) begin errors++; $display("FAIL reset_b_flags: vld=%b ovf=%b want 0 0", vld_b, ovf_b); end
        checks++; if (hit_b !== 4'h0 || cnt_b !== 16'h0) begin errors++; $display("FAIL reset_b_data: hit=%h cnt=%h want 0 0", hit_b, cnt_b); end
    endtask

    task automatic test_basic;
        st_a = 1'b1; tick(); st_a = 1'b0;              // E0
        for (int n = 1; n <= 9; n++) begin
            sp_a = {n == 9, n == 5, n == 5, n == 3};
            tick();
            sp_a = 4'h0;
            if (n == 8) begin
                checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b want 0", vld_a); end
            end
        end
        checks++; if (vld_a !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", vld_a); end
        checks++; if (cnt_a !== {12'd9, 12'd5, 12'd5, 12'd3}) begin errors++; $display("FAIL basic_counts: got %h want 009005005003", cnt_a); end
        checks++; if (hit_a !== 4'hF) begin errors++; $display("FAIL basic_hit: got %h want f", hit_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", ovf_a); end
        ak_a = 1'b1; tick(); ak_a = 1'b0;
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL basic_ack_valid: got %b want 0", vld_a); end
        checks++; if (cnt_a[47:36] !== 12'd9 || hit_a !== 4'hF) begin errors++; $display("FAIL basic_hold: ch3=%0d hit=%h want 9 f", cnt_a[47:36], hit_a); end
    endtask

    task automatic test_overflow;
        st_b = 1'b1; tick(); st_b = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            sp_b = {3'b000, n == 2};
            tick();
            sp_b = 4'h0;
            if (n == 14) begin
                checks++; if (vld_b !== 1'b0) begin errors++; $display("FAIL ovf_valid_early: got %b want 0", vld_b); end
            end
        end
        checks++; if (vld_b !== 1'b1 || ovf_b !== 1'b1) begin errors++; $display("FAIL ovf_flags: vld=%b ovf=%b want 1 1", vld_b, ovf_b); end
        checks++; if (hit_b !== 4'b0001) begin errors++; $display("FAIL ovf_hit: got %b want 0001", hit_b); end
        checks++; if (cnt_b !== 16'hFFF2) begin errors++; $display("FAIL ovf_counts: got %h want fff2", cnt_b); end
        ak_b = 1'b1; tick(); ak_b = 1'b0;
    endtask

    task automatic test_max_count;
        st_b = 1'b1; tick(); st_b = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            sp_b = (n == 1) ? 4'b0111 : ((n == 14) ? 4'b1000 : 4'b0000);
            tick();
            sp_b = 4'h0;
        end
        checks++; if (vld_b !== 1'b1 || ovf_b !== 1'b0) begin errors++; $display("FAIL max_flags: vld=%b ovf=%b want 1 0", vld_b, ovf_b); end
        checks++; if (cnt_b !== 16'hE111 || hit_b !== 4'hF) begin errors++; $display("FAIL max_counts: cnt=%h hit=%h want e111 f", cnt_b, hit_b); end
        ak_b = 1'b1; tick(); ak_b = 1'b0;
    endtask

    task automatic test_boundary;
        st_b = 1'b1; tick(); st_b = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            sp_b = (n == 1) ? 4'b0111 : ((n == 15) ? 4'b1000 : 4'b0000);
            tick();
            sp_b = 4'h0;
        end
        checks++; if (vld_b !== 1'b1 || ovf_b !== 1'b0) begin errors++; $display("FAIL bound_flags: vld=%b ovf=%b want 1 0", vld_b, ovf_b); end
        checks++; if (cnt_b !== 16'hF111 || hit_b !== 4'hF) begin errors++; $display("FAIL bound_counts: cnt=%h hit=%h want f111 f", cnt_b, hit_b); end
        ak_b = 1'b1; tick(); ak_b = 1'b0;
    endtask

    task automatic test_repeat_stray;
        st_a = 1'b1; tick(); st_a = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            sp_a = (n == 2 || n == 4) ? 4'b0001 : ((n == 5) ? 4'b1110 : 4'b0000);
            st_a = (n == 3);
            tick();
            sp_a = 4'h0;
            st_a = 1'b0;
        end
        checks++; if (vld_a !== 1'b1) begin errors++; $display("FAIL rep_valid: got %b want 1", vld_a); end
        checks++; if (cnt_a !== {12'd5, 12'd5, 12'd5, 12'd2}) begin errors++; $display("FAIL rep_counts: got %h want 005005005002", cnt_a); end
        st_a = 1'b1; tick(); st_a = 1'b0;              // start alone in DONE
        checks++; if (vld_a !== 1'b1 || hit_a !== 4'hF) begin errors++; $display("FAIL rep_start_done: vld=%b hit=%h want 1 f", vld_a, hit_a); end
        st_a = 1'b1; ak_a = 1'b1; tick(); st_a = 1'b0; ak_a = 1'b0;
        checks++; if (vld_a !== 1'b0 || hit_a !== 4'hF) begin errors++; $display("FAIL rep_start_ack: vld=%b hit=%h want 0 f", vld_a, hit_a); end
        tick();
        checks++; if (hit_a !== 4'hF || cnt_a[11:0] !== 12'd2) begin errors++; $display("FAIL rep_idle_hold: hit=%h ch0=%0d want f 2", hit_a, cnt_a[11:0]); end
    endtask

    task automatic test_reset_mid;
        st_a = 1'b1; tick(); st_a = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            sp_a = (n == 2) ? 4'b0001 : 4'b0000;
            rst  = (n == 4);
            tick();
            sp_a = 4'h0;
            rst  = 1'b0;
            if (n == 2) begin
                checks++; if (hit_a !== 4'b0001 || cnt_a[11:0] !== 12'd2) begin errors++; $display("FAIL rst_pre: hit=%b ch0=%0d want 0001 2", hit_a, cnt_a[11:0]); end
            end
        end
        checks++; if (vld_a !== 1'b0 || ovf_a !== 1'b0 || hit_a !== 4'h0 || cnt_a !== 48'h0) begin errors++; $display("FAIL rst_mid: vld=%b ovf=%b hit=%h cnt=%h want all 0", vld_a, ovf_a, hit_a, cnt_a); end
        for (int n = 5; n <= 9; n++) begin             // stops while IDLE
            sp_a = (n >= 6 && n <= 8) ? 4'hF : 4'h0;
            tick();
        end
        sp_a = 4'h0;
        checks++; if (hit_a !== 4'h0 || cnt_a !== 48'h0 || vld_a !== 1'b0) begin errors++; $display("FAIL idle_stops: hit=%h cnt=%h vld=%b want 0 0 0", hit_a, cnt_a, vld_a); end
        st_a = 1'b1; tick(); st_a = 1'b0;              // E10
        for (int n = 11; n <= 13; n++) begin
            sp_a = (n == 13) ? 4'hF : 4'h0;
            tick();
            sp_a = 4'h0;
        end
        checks++; if (vld_a !== 1'b1 || cnt_a !== {4{12'd3}}) begin errors++; $display("FAIL rst_restart: vld=%b cnt=%h want 1 003003003003", vld_a, cnt_a); end
        ak_a = 1'b1; tick(); ak_a = 1'b0;
    endtask

    task automatic test_stop_edge;
        logic [11:0] exp_ch0;
`ifdef CC_STOP_EDGE_EN
        exp_ch0 = 12'd6;
`else
        exp_ch0 = 12'd1;
`endif
        sp_a = 4'b0001; tick();                         // high before E0
        st_a = 1'b1; tick(); st_a = 1'b0;              // E0
        for (int n = 1; n <= 8; n++) begin
            sp_a[0]   = !(n >= 3 && n <= 5);
            sp_a[3:1] = (n == 8) ? 3'b111 : 3'b000;
            tick();
        end
        sp_a = 4'h0;
        checks++; if (cnt_a[11:0] !== exp_ch0) begin errors++; $display("FAIL edge_ch0: got %0d want %0d", cnt_a[11:0], exp_ch0); end
        checks++; if (cnt_a[47:12] !== {3{12'd8}} || hit_a !== 4'hF || vld_a !== 1'b1) begin errors++; $display("FAIL edge_rest: cnt=%h hit=%h vld=%b want 008008008 f 1", cnt_a[47:12], hit_a, vld_a); end
        ak_a = 1'b1; tick(); ak_a = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        st_a = 1'b0; ak_a = 1'b0; sp_a = 4'h0;
        st_b = 1'b0; ak_b = 1'b0; sp_b = 4'h0;
        tick();
        test_reset();
        test_basic();
        test_overflow();
        test_max_count();
        test_boundary();
        test_repeat_stray();
        test_reset_mid();
        test_stop_edge();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
